// File: rtl/data_memory_lsu.sv
// Word-organised data memory with RV32I byte/half/word load-store sizing and
// sticky capture of misaligned or invalid accesses.
module data_memory_lsu #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Address,
  input  logic [31:0] DataWr,
  input  logic        DMWr,
  input  logic        DMRd,
  input  logic [2:0]  DMCtrl,
  output logic [31:0] DataRd,
  output logic        misaligned,
  output logic        fault_sticky,
  output logic [31:0] fault_addr,
  output logic [7:0]  fault_count
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;
  logic          wr_en;
  logic          fault;

  logic        fault_sticky_q, fault_sticky_d;
  logic [31:0] fault_addr_q, fault_addr_d;
  logic [7:0]  fault_count_q, fault_count_d;

  assign idx     = Address[AW+1:2];
  assign lane    = Address[1:0];
  assign rd_word = mem_q[idx];
  assign rd_byte = rd_word[8*lane +: 8];
  assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

  // Unsigned sizes are load-only, so they become invalid whenever a store is requested.
  always_comb begin
    misaligned = 1'b0;
    unique case (DMCtrl)
      3'b000:  misaligned = 1'b0;
      3'b001:  misaligned = lane[0];
      3'b010:  misaligned = (lane != 2'b00);
      3'b100:  misaligned = DMWr;
      3'b101:  misaligned = DMWr | lane[0];
      default: misaligned = 1'b1;
    endcase
  end

  always_comb begin
    DataRd = 32'h0;
    if (!misaligned) begin
      unique case (DMCtrl)
        3'b000:  DataRd = {{24{rd_byte[7]}}, rd_byte};
        3'b100:  DataRd = {24'h0, rd_byte};
        3'b001:  DataRd = {{16{rd_half[15]}}, rd_half};
        3'b101:  DataRd = {16'h0, rd_half};
        default: DataRd = rd_word;
      endcase
    end
  end

  always_comb begin
    wr_be   = 4'b0000;
    wr_data = DataWr;
    unique case (DMCtrl)
      3'b000: begin
        wr_be   = 4'b0001 << lane;
        wr_data = {4{DataWr[7:0]}};
      end
      3'b001: begin
        wr_be   = lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{DataWr[15:0]}};
      end
      3'b010:  wr_be = 4'b1111;
      default: wr_be = 4'b0000;
    endcase
  end

  assign wr_en = DMWr & ~rst & ~misaligned;

  // Contents survive reset; only the fault bookkeeping is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem_q[idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign fault = misaligned & (DMWr | DMRd);

  always_comb begin
    fault_sticky_d = fault_sticky_q;
    fault_addr_d   = fault_addr_q;
    fault_count_d  = fault_count_q;
    if (fault) begin
      fault_sticky_d = 1'b1;
      if (!fault_sticky_q) fault_addr_d = Address;
      if (fault_count_q != 8'hFF) fault_count_d = fault_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_sticky_q <= 1'b0;
      fault_addr_q   <= 32'h0;
      fault_count_q  <= 8'h0;
    end else begin
      fault_sticky_q <= fault_sticky_d;
      fault_addr_q   <= fault_addr_d;
      fault_count_q  <= fault_count_d;
    end
  end

  assign fault_sticky = fault_sticky_q;
  assign fault_addr   = fault_addr_q;
  assign fault_count  = fault_count_q;

endmodule
